fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/cpu_pkg.sv | 12 +
 rtl/fetch_queue_mem.sv | 30 +++
 rtl/fetch_queue.sv | 123 ++++++++++++
 tb/tb_fetch_queue.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction width, NOP encoding and PC step.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;

  // addi x0, x0, 0
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  // Byte distance between consecutive sequential fetches.
  localparam int unsigned PC_INC = 4;

endpackage : cpu_pkg

// File: rtl/fetch_queue_mem.sv
// Queue storage: DEPTH entries of {pc, instr}, synchronous write, asynchronous read.
module fetch_queue_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64,
  parameter int unsigned AW    = 2
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  // Contents carry no reset: validity is tracked by the controller's count.
  logic [W-1:0] mem_q [DEPTH];

  // Write one entry on a push.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Head entry read is combinational so ID sees it in the cycle after the push.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule : fetch_queue_mem

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches sequentially from a combinational instruction
// memory into a small FIFO feeding the ID stage; a flush redirects the fetch PC.
//
// Handshake toward ID: id_valid_o means the head entry is valid; stall_i acts as
// an inverted ready. The head is consumed (popped) on a cycle where id_valid_o=1
// and stall_i=0, unless flush_i=1, in which case the whole queue is discarded.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned       XLEN     = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic [XLEN-1:0]            imem_addr_o,
  input  logic [INSTR_W-1:0]         imem_instr_i,
  output logic                       id_valid_o,
  output logic [XLEN-1:0]            id_pc_o,
  output logic [INSTR_W-1:0]         id_instr_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = XLEN + INSTR_W;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            not_empty;
  logic            full;
  logic            push;
  logic            pop;
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   rd_entry;

  // Push/pop decisions; flush suppresses both.
  always_comb begin
    not_empty = (count_q != '0);
    full      = (count_q == CW'(DEPTH));
    pop       = not_empty & ~stall_i & ~flush_i;
    push      = start_i & ~flush_i & (~full | pop);
    wr_entry  = {fetch_pc_q, imem_instr_i};
  end

  // Next-state for fetch PC, pointers and occupancy.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (flush_i) begin
      fetch_pc_d = redirect_pc_i;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        // Wraps modulo 2^XLEN by construction.
        fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
        wptr_d     = wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc_q <= RESET_PC;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .W     (EW),
    .AW    (PW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rptr_q),
    .rdata_o (rd_entry)
  );

  // Outputs: head comes from storage only; empty queue presents a NOP at PC 0.
  always_comb begin
    imem_addr_o = fetch_pc_q;
    id_valid_o  = not_empty;
    count_o     = count_q;
    if (not_empty) begin
      id_pc_o    = rd_entry[EW-1:INSTR_W];
      id_instr_o = rd_entry[INSTR_W-1:0];
    end else begin
      id_pc_o    = '0;
      id_instr_o = NOP_INSTR;
    end
  end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a combinational instruction memory model.
module tb_fetch_queue;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic [2:0]  count_o;

  int n_assert;
  int n_fail;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_queue dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_instr_i  (imem_instr_i),
    .id_valid_o    (id_valid_o),
    .id_pc_o       (id_pc_o),
    .id_instr_o    (id_instr_o),
    .count_o       (count_o)
  );

  // Clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Instruction memory: each word is its address with a fixed tag pattern.
  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign imem_instr_i = instr_at(imem_addr_o);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst_i         = 1'b0;
    start_i       = 1'b0;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    redirect_pc_i = '0;

    // Reset state
    #2;
    check("rst_count", 32'(count_o), 0);
    check("rst_valid", 32'(id_valid_o), 0);
    check("rst_instr", id_instr_o, NOP);
    check("rst_pc", id_pc_o, 0);
    check("rst_addr", imem_addr_o, 0);
    tick();
    rst_i = 1'b1;

    // Fill with stall held: pushes 0,4,8,12
    start_i = 1'b1;
    stall_i = 1'b1;
    tick();
    check("fill1_count", 32'(count_o), 1);
    check("fill1_valid", 32'(id_valid_o), 1);
    check("fill1_pc", id_pc_o, 0);
    check("fill1_instr", id_instr_o, instr_at(0));
    for (int i = 2; i <= 4; i++) begin
      tick();
      check("fill_count", 32'(count_o), 32'(i));
    end
    check("full_addr", imem_addr_o, 16);
    tick();
    check("full_hold_count", 32'(count_o), 4);
    check("full_hold_addr", imem_addr_o, 16);
    check("full_hold_pc", id_pc_o, 0);

    // Full, stall released: simultaneous push/pop across pointer wrap
    stall_i = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      check("stream_pc", id_pc_o, 32'(4 * i));
      check("stream_instr", id_instr_o, instr_at(32'(4 * i)));
      tick();
      check("stream_count", 32'(count_o), 4);
    end
    check("stream_head", id_pc_o, 24);
    check("stream_addr", imem_addr_o, 40);

    // Drain to 3 entries, then flush to 0x100 with start still high
    start_i = 1'b0;
    tick();
    check("drain_count", 32'(count_o), 3);
    check("drain_head", id_pc_o, 28);
    start_i       = 1'b1;
    flush_i       = 1'b1;
    redirect_pc_i = 32'h100;
    tick();
    check("flush_count", 32'(count_o), 0);
    check("flush_valid", 32'(id_valid_o), 0);
    check("flush_instr", id_instr_o, NOP);
    check("flush_pc", id_pc_o, 0);
    check("flush_addr", imem_addr_o, 32'h100);
    flush_i = 1'b0;
    stall_i = 1'b1;
    tick();
    check("redir_pc", id_pc_o, 32'h100);
    check("redir_instr", id_instr_o, instr_at(32'h100));
    check("redir_count", 32'(count_o), 1);

    // Drain and idle with start low
    start_i = 1'b0;
    stall_i = 1'b0;
    tick();
    check("idle0_count", 32'(count_o), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_valid", 32'(id_valid_o), 0);
      check("idle_addr", imem_addr_o, 32'h104);
    end

    // Two entries, then an asynchronous reset pulse between edges
    start_i = 1'b1;
    stall_i = 1'b1;
    tick();
    tick();
    check("pre_rst_count", 32'(count_o), 2);
    check("pre_rst_addr", imem_addr_o, 32'h10C);
    #2;
    rst_i = 1'b0;
    #1;
    check("arst_count", 32'(count_o), 0);
    check("arst_valid", 32'(id_valid_o), 0);
    check("arst_instr", id_instr_o, NOP);
    check("arst_pc", id_pc_o, 0);
    check("arst_addr", imem_addr_o, 0);
    #2;
    rst_i = 1'b1;
    tick();
    check("post_rst_valid", 32'(id_valid_o), 1);
    check("post_rst_pc", id_pc_o, 0);
    check("post_rst_instr", id_instr_o, instr_at(0));
    tick();
    tick();
    tick();
    check("refill_count", 32'(count_o), 4);
    check("refill_addr", imem_addr_o, 16);

    // Flush and stall together on a full queue: flush wins
    flush_i       = 1'b1;
    redirect_pc_i = 32'h200;
    tick();
    check("fs_count", 32'(count_o), 0);
    check("fs_valid", 32'(id_valid_o), 0);
    check("fs_addr", imem_addr_o, 32'h200);
    flush_i = 1'b0;
    tick();
    check("fs_next_pc", id_pc_o, 32'h200);
    check("fs_next_count", 32'(count_o), 1);

    // PC wraps modulo 2^32
    flush_i       = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    flush_i = 1'b0;
    tick();
    check("wrap_pc", id_pc_o, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr_o, 0);
    tick();
    check("wrap_count", 32'(count_o), 2);
    check("wrap_addr2", imem_addr_o, 4);
    check("wrap_head", id_pc_o, 32'hFFFF_FFFC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_fetch_queue
